// File: rtl/mem_bus_responder_pkg.sv
// Shared widths and response record for the memory bus responder.
// MEM_RESP_ERR_EN adds an out-of-range error flag to the response record.
package mem_bus_responder_pkg;

  localparam int MEM_WORD_W = 32;
  localparam int MEM_ADDR_W = 32;

  typedef struct packed {
`ifdef MEM_RESP_ERR_EN
    logic                  err;
`endif
    logic                  is_write;
    logic [MEM_WORD_W-1:0] rdata;
  } rsp_t;

  localparam int RSP_W = $bits(rsp_t);

endpackage

// File: rtl/mem_bus_responder_if.sv
// Valid/ready request and response bus between the cpu-side initiator and the responder.
// MEM_RESP_ERR_EN adds the rsp_err signal.
interface mem_bus_responder_if;
  import mem_bus_responder_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [MEM_ADDR_W-1:0] req_addr;
  logic                  req_wen;
  logic [MEM_WORD_W-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [MEM_WORD_W-1:0] rsp_rdata;
  logic                  rsp_is_write;
`ifdef MEM_RESP_ERR_EN
  logic                  rsp_err;
`endif

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_is_write
`ifdef MEM_RESP_ERR_EN
    , input rsp_err
`endif
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_is_write
`ifdef MEM_RESP_ERR_EN
    , output rsp_err
`endif
  );

endinterface

// File: rtl/mem_bus_responder_resp_fifo.sv
// Synchronous-reset response FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module resp_fifo #(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok   = push & !full;
  assign pop_ok    = pop & !empty;
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign head_data = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Word-memory responder: fixed-latency pipeline into a response FIFO with credit-style backpressure.
// MEM_RESP_ERR_EN: addresses >= DEPTH are rejected with rsp_err; otherwise addresses wrap.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int DEPTH      = 2048,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  mem_bus_responder_if.slave bus
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + LATENCY) + 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  logic [MEM_WORD_W-1:0] mem [DEPTH];
  rsp_t                  pipe_data [LATENCY];
  logic [LATENCY-1:0]    pipe_valid;
  logic [CW-1:0]         outstanding;
  logic [AW-1:0]         idx;
  logic                  in_range;
  logic                  accept;
  logic                  pop;
  rsp_t                  new_rsp;
  rsp_t                  head;
  logic                  fifo_empty;
  logic                  unused_fifo_full;
  logic [FCW-1:0]        unused_fifo_count;

  assign idx = bus.req_addr[AW-1:0];

`ifdef MEM_RESP_ERR_EN
  assign in_range = (bus.req_addr[MEM_ADDR_W-1:AW] == '0);
`else
  logic unused_addr_hi;
  assign in_range       = 1'b1;
  assign unused_addr_hi = ^bus.req_addr[MEM_ADDR_W-1:AW];
`endif

  // Counting pipeline entries as well as FIFO entries reserves a slot for every accepted op,
  // so the FIFO can never overflow and the pipeline never needs to stall.
  assign bus.req_ready = !rst && (outstanding < CW'(FIFO_DEPTH));
  assign accept        = bus.req_valid & bus.req_ready;
  assign pop           = bus.rsp_valid & bus.rsp_ready;

  always_comb begin
    new_rsp          = '0;
    new_rsp.is_write = bus.req_wen;
    if (!bus.req_wen && in_range) new_rsp.rdata = mem[idx];
`ifdef MEM_RESP_ERR_EN
    new_rsp.err = !in_range;
`endif
  end

  always_ff @(posedge clk) begin
    if (accept && bus.req_wen && in_range) mem[idx] <= bus.req_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= accept;
      for (int i = 1; i < LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_data[0] <= new_rsp;
    for (int i = 1; i < LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  resp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pipe_valid[LATENCY-1]),
    .push_data (pipe_data[LATENCY-1]),
    .pop       (pop),
    .head_data (head),
    .full      (unused_fifo_full),
    .empty     (fifo_empty),
    .count     (unused_fifo_count)
  );

  // Storage is not reset, so outputs are forced to zero whenever the FIFO is empty.
  assign bus.rsp_valid    = !fifo_empty;
  assign bus.rsp_rdata    = fifo_empty ? '0 : head.rdata;
  assign bus.rsp_is_write = fifo_empty ? 1'b0 : head.is_write;
`ifdef MEM_RESP_ERR_EN
  assign bus.rsp_err      = fifo_empty ? 1'b0 : head.err;
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: directed cases plus randomized traffic vs a behavioural memory model.
module tb_mem_bus_responder;
  import mem_bus_responder_pkg::*;

  localparam int DEPTH = 2048;
  localparam int LAT   = 2;
  localparam int FD    = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        is_write;
    logic        err;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_bus_responder_if bus();

  mem_bus_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .FIFO_DEPTH(FD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        exp_q[$];
  logic [31:0] mdl [DEPTH];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference model: a flat word array; the response is decided entirely at accept time.
  task automatic model_req(input logic [31:0] a, input logic w, input logic [31:0] d, input int acc_c);
    exp_t e;
    int   i;
    bit   ok;
    i  = int'(a % DEPTH);
`ifdef MEM_RESP_ERR_EN
    ok = (a < DEPTH);
`else
    ok = 1'b1;
`endif
    e.is_write = w;
    e.err      = !ok;
    e.acc      = acc_c;
    e.rdata    = 32'h0;
    if (w) begin
      if (ok) mdl[i] = d;
    end else if (ok) begin
      e.rdata = mdl[i];
    end
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every handshaken response.
  always @(negedge clk) begin
    exp_t e;
    bit   good;
    if (!rst && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rsp: got rdata %0h is_write %0b with no response outstanding",
                 bus.rsp_rdata, bus.rsp_is_write);
      end else begin
        e    = exp_q.pop_front();
        good = (bus.rsp_rdata === e.rdata) && (bus.rsp_is_write === e.is_write) && (cyc >= e.acc + LAT);
`ifdef MEM_RESP_ERR_EN
        good = good && (bus.rsp_err === e.err);
`endif
        if (!good) begin
          n_fail++;
          $display("FAIL rsp_cmp: got rdata %0h is_write %0b cycle %0d, expected rdata %0h is_write %0b err %0b cycle >= %0d",
                   bus.rsp_rdata, bus.rsp_is_write, cyc, e.rdata, e.is_write, e.err, e.acc + LAT);
        end
      end
    end
  end

  // One bus cycle: present inputs, sample ready away from the edge, advance past the edge.
  task automatic cycle_drive(input logic v, input logic [31:0] a, input logic w, input logic [31:0] d,
                             output bit acc, output int acc_c);
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_wen   = w;
    bus.req_wdata = d;
    if (rand_rdy) bus.rsp_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    acc   = v && (bus.req_ready === 1'b1);
    acc_c = cyc + 1;
    if (acc) model_req(a, w, d, acc_c);
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] d, output int acc_c);
    bit acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) cycle_drive(1'b1, a, w, d, acc, acc_c);
    bus.req_valid = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_timeout: got no accept for addr %0h expected accept within 50 cycles", a);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    int c;
    for (int k = 0; k < n; k++) cycle_drive(1'b0, 32'h0, 1'b0, 32'h0, acc, c);
  endtask

  task automatic drain();
    rand_rdy      = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) idle(1);
    idle(3);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish before 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    int  c, k0, seen, n_acc, n_v;
    bit  acc;
    logic [31:0] a, v7;

    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wen   = 1'b0;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_is_write", bus.rsp_is_write, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", bus.req_ready, 1);
    @(posedge clk); #1;

    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) do_req(i, 1'b1, $urandom, c);
    drain();

    // Idle-pipeline read latency
    do_req(32'd3, 1'b0, 32'h0, k0);
    seen = -1;
    for (int k = 0; k < 12 && seen < 0; k++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) seen = cyc;
    end
    @(posedge clk); #1;
    check("read_latency", seen - k0, LAT);
    drain();

    // Write then read-after-write to the same address
    do_req(32'd5, 1'b1, 32'hDEADBEEF, c);
    do_req(32'd5, 1'b0, 32'h0, c);
    drain();

    // Backpressure: FIFO fills to FD and stops accepting
    bus.rsp_ready = 1'b0;
    n_acc = 0;
    for (int k = 0; k < 8; k++) begin
      cycle_drive(1'b1, $urandom_range(0, 15), 1'b0, 32'h0, acc, c);
      if (acc) n_acc++;
    end
    bus.req_valid = 1'b0;
    check("fill_accepts", n_acc, FD);
    check("full_ready_low", bus.req_ready, 0);
    bus.rsp_ready = 1'b1;
    n_v = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) n_v++;
      if (k == 0) check("ready_before_pop", bus.req_ready, 0);
      if (k == 1) check("ready_after_pop", bus.req_ready, 1);
      @(posedge clk); #1;
    end
    check("b2b_rsp", n_v, 4);
    drain();

    // Sustained streaming starting from a full FIFO
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 6; k++) cycle_drive(1'b1, $urandom_range(0, 15), 1'b0, 32'h0, acc, c);
    bus.rsp_ready = 1'b1;
    n_acc = 0;
    for (int k = 0; k < 20; k++) begin
      cycle_drive(1'b1, $urandom_range(0, 15), 1'b0, 32'h0, acc, c);
      if (acc) n_acc++;
    end
    bus.req_valid = 1'b0;
    check("stream_accepts", n_acc, 19);
    drain();

    // Reset with responses in flight; the accepted write survives
    v7 = $urandom;
    bus.rsp_ready = 1'b0;
    do_req(32'd7, 1'b1, v7, c);
    for (int k = 0; k < 3; k++) do_req($urandom_range(0, 15), 1'b0, 32'h0, c);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_req_ready", bus.req_ready, 0);
    exp_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_rsp_valid", bus.rsp_valid, 0);
    check("rst_mid_rsp_rdata", bus.rsp_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready_back", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    n_v = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) n_v++;
      @(posedge clk); #1;
    end
    check("no_stale_rsp", n_v, 0);
    do_req(32'd7, 1'b0, 32'h0, c);
    drain();

    // Address beyond DEPTH
    do_req(32'd0, 1'b1, 32'h12345678, c);
    do_req(32'd2048, 1'b1, 32'h1, c);
    do_req(32'd2048, 1'b0, 32'h0, c);
    do_req(32'd0, 1'b0, 32'h0, c);
    drain();

    // Randomized traffic with random backpressure
    rand_rdy = 1'b1;
    for (int k = 0; k < 300; k++) begin
      a = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 3)) << 11);
      cycle_drive($urandom_range(0, 4) != 0, a, 1'($urandom_range(0, 1)), $urandom, acc, c);
    end
    bus.req_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
